// File: rtl/ex_wb_arbiter.sv
// Round-robin arbiter sharing the register-file writeback port among execution units.
// Null (r0) requests are acknowledged alongside the real winner without using the port.
module ex_wb_arbiter #(
    parameter int unsigned NUM_UNITS = 4,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned RN_W      = 6,
    parameter int unsigned PERF_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_UNITS-1:0]        unit_valid,
    input  logic [NUM_UNITS*DATA_W-1:0] unit_data,
    input  logic [NUM_UNITS*RN_W-1:0]   unit_rn,
    output logic [NUM_UNITS-1:0]        unit_stall,
    input  logic                        wb_stall,
    output logic                        wb_en,
    output logic [RN_W-1:0]             wb_rn,
    output logic [DATA_W-1:0]           wb_data,
    output logic [2:0]                  wb_unit,
    output logic [PERF_W-1:0]           perf_conflicts
);

    localparam int unsigned PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    logic [PTR_W-1:0]       rr_ptr_q;
    logic [PTR_W-1:0]       rr_ptr_d;
    logic [NUM_UNITS-1:0]   real_req;
    logic [NUM_UNITS-1:0]   null_req;
    logic [2*NUM_UNITS-1:0] req_dbl;
    logic [NUM_UNITS-1:0]   req_rot;
    logic                   win_found;
    logic [PTR_W-1:0]       win_off;
    logic [PTR_W:0]         win_sum;
    logic [PTR_W-1:0]       win_idx;
    logic [NUM_UNITS-1:0]   win_onehot;
    logic [NUM_UNITS-1:0]   grant;
    logic [PTR_W:0]         n_real;
    logic                   multi_req;
    logic [RN_W-1:0]        sel_rn;
    logic [DATA_W-1:0]      sel_data;

    always_comb begin
        real_req = '0;
        null_req = '0;
        n_real   = '0;
        for (int i = 0; i < int'(NUM_UNITS); i++) begin
            real_req[i] = unit_valid[i] & (|unit_rn[i*RN_W +: RN_W]);
            null_req[i] = unit_valid[i] & ~(|unit_rn[i*RN_W +: RN_W]);
            n_real      = n_real + (PTR_W+1)'(real_req[i]);
        end
        multi_req = n_real > (PTR_W+1)'(1);
    end

    // Rotate requests so bit 0 is the unit at rr_ptr; the lowest set bit is the winner offset.
    always_comb begin
        req_dbl   = {real_req, real_req} >> rr_ptr_q;
        req_rot   = req_dbl[NUM_UNITS-1:0];
        win_found = 1'b0;
        win_off   = '0;
        for (int i = int'(NUM_UNITS) - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                win_found = 1'b1;
                win_off   = PTR_W'(i);
            end
        end
        win_sum = {1'b0, rr_ptr_q} + {1'b0, win_off};
        if (win_sum >= (PTR_W+1)'(NUM_UNITS)) begin
            win_sum = win_sum - (PTR_W+1)'(NUM_UNITS);
        end
        win_idx    = win_sum[PTR_W-1:0];
        win_onehot = win_found ? (NUM_UNITS'(1) << win_idx) : '0;
        rr_ptr_d   = (win_idx == PTR_W'(NUM_UNITS - 1)) ? '0 : win_idx + PTR_W'(1);
    end

    always_comb begin
        sel_rn   = '0;
        sel_data = '0;
        for (int i = 0; i < int'(NUM_UNITS); i++) begin
            if (win_onehot[i]) begin
                sel_rn   = unit_rn[i*RN_W +: RN_W];
                sel_data = unit_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        grant      = wb_stall ? '0 : (win_onehot | null_req);
        unit_stall = unit_valid & ~grant;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_en          <= 1'b0;
            wb_rn          <= '0;
            wb_data        <= '0;
            wb_unit        <= '0;
            rr_ptr_q       <= '0;
            perf_conflicts <= '0;
        end else if (!wb_stall) begin
            wb_en <= win_found;
            if (win_found) begin
                wb_rn    <= sel_rn;
                wb_data  <= sel_data;
                wb_unit  <= 3'(win_idx);
                rr_ptr_q <= rr_ptr_d;
            end
            if (multi_req && (perf_conflicts != '1)) begin
                perf_conflicts <= perf_conflicts + PERF_W'(1);
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!$isunknown(unit_valid))
            else $error("ex_wb_arbiter: unit_valid has X bits after reset");
        end
    end
`endif

endmodule

// File: tb/tb_ex_wb_arbiter.sv
// Directed bench for ex_wb_arbiter: 4 units, 4-bit conflict counter to reach saturation quickly.
module tb_ex_wb_arbiter;

    localparam int unsigned NU = 4;
    localparam int unsigned DW = 64;
    localparam int unsigned RW = 6;
    localparam int unsigned PW = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NU-1:0]    unit_valid;
    logic [NU*DW-1:0] unit_data;
    logic [NU*RW-1:0] unit_rn;
    logic [NU-1:0]    unit_stall;
    logic             wb_stall;
    logic             wb_en;
    logic [RW-1:0]    wb_rn;
    logic [DW-1:0]    wb_data;
    logic [2:0]       wb_unit;
    logic [PW-1:0]    perf_conflicts;

    int checks   = 0;
    int failures = 0;

    ex_wb_arbiter #(
        .NUM_UNITS(NU),
        .DATA_W   (DW),
        .RN_W     (RW),
        .PERF_W   (PW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .unit_valid    (unit_valid),
        .unit_data     (unit_data),
        .unit_rn       (unit_rn),
        .unit_stall    (unit_stall),
        .wb_stall      (wb_stall),
        .wb_en         (wb_en),
        .wb_rn         (wb_rn),
        .wb_data       (wb_data),
        .wb_unit       (wb_unit),
        .perf_conflicts(perf_conflicts)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_unit(input int i, input logic v, input logic [RW-1:0] rn,
                            input logic [DW-1:0] d);
        unit_valid[i]        = v;
        unit_rn[i*RW +: RW]  = rn;
        unit_data[i*DW +: DW] = d;
        #1;
    endtask

    task automatic chk_beat(input string tag, input logic [RW-1:0] rn, input logic [DW-1:0] d,
                            input logic [2:0] u);
        chk({tag, ".en"}, 64'(wb_en), 64'd1);
        chk({tag, ".rn"}, 64'(wb_rn), 64'(rn));
        chk({tag, ".data"}, wb_data, d);
        chk({tag, ".unit"}, 64'(wb_unit), 64'(u));
    endtask

    initial begin
        rst_n      = 1'b0;
        unit_valid = '0;
        unit_data  = '0;
        unit_rn    = '0;
        wb_stall   = 1'b0;
        #1;
        chk("rst.en", 64'(wb_en), 64'd0);
        chk("rst.rn", 64'(wb_rn), 64'd0);
        chk("rst.data", wb_data, 64'd0);
        chk("rst.unit", 64'(wb_unit), 64'd0);
        chk("rst.perf", 64'(perf_conflicts), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single request from unit 2; rr_ptr becomes 3
        set_unit(2, 1'b1, 6'd5, 64'hDEAD_BEEF);
        chk("single.stall", 64'(unit_stall), 64'b0000);
        tick();
        chk_beat("single", 6'd5, 64'hDEAD_BEEF, 3'd2);
        set_unit(2, 1'b0, 6'd0, 64'd0);
        tick();
        chk("idle.en", 64'(wb_en), 64'd0);
        chk("idle.rn_hold", 64'(wb_rn), 64'd5);

        // Wrap: rr_ptr=3, units 0 and 3 -> 3 wins, then 0
        set_unit(0, 1'b1, 6'd10, 64'hA0);
        set_unit(3, 1'b1, 6'd13, 64'hA3);
        chk("wrap.stall0", 64'(unit_stall), 64'b0001);
        tick();
        chk_beat("wrap.beat0", 6'd13, 64'hA3, 3'd3);
        chk("wrap.perf", 64'(perf_conflicts), 64'd1);
        set_unit(3, 1'b0, 6'd0, 64'd0);
        chk("wrap.stall1", 64'(unit_stall), 64'b0000);
        tick();
        chk_beat("wrap.beat1", 6'd10, 64'hA0, 3'd0);
        set_unit(0, 1'b0, 6'd0, 64'd0);

        // r0 discard: rr_ptr=1, unit 1 null, unit 2 real
        set_unit(1, 1'b1, 6'd0, 64'h11);
        set_unit(2, 1'b1, 6'd7, 64'h22);
        chk("r0.stall", 64'(unit_stall), 64'b0000);
        tick();
        chk_beat("r0.beat", 6'd7, 64'h22, 3'd2);
        set_unit(1, 1'b0, 6'd0, 64'd0);
        set_unit(2, 1'b0, 6'd0, 64'd0);
        tick();
        chk("r0.en_once", 64'(wb_en), 64'd0);
        chk("r0.perf", 64'(perf_conflicts), 64'd1);

        // Downstream stall for 3 cycles with units 0 and 1 valid; rr_ptr=3
        wb_stall = 1'b1;
        set_unit(0, 1'b1, 6'd1, 64'hB0);
        set_unit(1, 1'b1, 6'd2, 64'hB1);
        for (int c = 0; c < 3; c++) begin
            chk("wbs.stall", 64'(unit_stall), 64'b0011);
            tick();
            chk("wbs.en", 64'(wb_en), 64'd0);
            chk("wbs.rn", 64'(wb_rn), 64'd7);
            chk("wbs.unit", 64'(wb_unit), 64'd2);
            chk("wbs.perf", 64'(perf_conflicts), 64'd1);
        end
        wb_stall = 1'b0;
        #1;
        chk("wbs.rel_stall", 64'(unit_stall), 64'b0010);
        tick();
        chk_beat("wbs.rel0", 6'd1, 64'hB0, 3'd0);
        chk("wbs.rel_perf", 64'(perf_conflicts), 64'd2);
        set_unit(0, 1'b0, 6'd0, 64'd0);
        tick();
        chk_beat("wbs.rel1", 6'd2, 64'hB1, 3'd1);
        set_unit(1, 1'b0, 6'd0, 64'd0);

        // Asynchronous reset while a beat is on wb
        rst_n = 1'b0;
        #1;
        chk("arst.en", 64'(wb_en), 64'd0);
        chk("arst.rn", 64'(wb_rn), 64'd0);
        chk("arst.unit", 64'(wb_unit), 64'd0);
        chk("arst.perf", 64'(perf_conflicts), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Full contention from rr_ptr=0: grants 0,1,2,3
        for (int i = 0; i < 4; i++) set_unit(i, 1'b1, 6'(i + 1), 64'h100 + 64'(i));
        chk("full.stall0", 64'(unit_stall), 64'b1110);
        tick();
        chk_beat("full.g0", 6'd1, 64'h100, 3'd0);
        set_unit(0, 1'b0, 6'd0, 64'd0);
        chk("full.stall1", 64'(unit_stall), 64'b1100);
        tick();
        chk_beat("full.g1", 6'd2, 64'h101, 3'd1);
        set_unit(1, 1'b0, 6'd0, 64'd0);
        chk("full.stall2", 64'(unit_stall), 64'b1000);
        tick();
        chk_beat("full.g2", 6'd3, 64'h102, 3'd2);
        set_unit(2, 1'b0, 6'd0, 64'd0);
        chk("full.stall3", 64'(unit_stall), 64'b0000);
        tick();
        chk_beat("full.g3", 6'd4, 64'h103, 3'd3);
        chk("full.perf", 64'(perf_conflicts), 64'd3);
        set_unit(3, 1'b0, 6'd0, 64'd0);

        // Saturation: units 0 and 1 requesting for 20 cycles; rr_ptr=0 so grants alternate 0,1
        set_unit(0, 1'b1, 6'd8, 64'hC0);
        set_unit(1, 1'b1, 6'd9, 64'hC1);
        tick();
        chk("sat.g0", 64'(wb_unit), 64'd0);
        tick();
        chk("sat.g1", 64'(wb_unit), 64'd1);
        repeat (18) tick();
        chk("sat.perf", 64'(perf_conflicts), 64'hF);
        repeat (3) tick();
        chk("sat.hold", 64'(perf_conflicts), 64'hF);
        set_unit(0, 1'b0, 6'd0, 64'd0);
        set_unit(1, 1'b0, 6'd0, 64'd0);
        tick();
        tick();
        chk("sat.idle_en", 64'(wb_en), 64'd0);
        chk("sat.idle_perf", 64'(perf_conflicts), 64'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
